// File: rtl/abies_tone_pkg.sv
// Shared definitions for the tone controller.
//   glide_state_t : glide FSM states (HOLD, GLIDE_UP, GLIDE_DN)
//   tone_tw()     : tone table, entry i = 2048*(i+1) as a 32-bit value;
//                   callers truncate to their tuning-word width.
package abies_tone_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    GLIDE_UP = 2'd1,
    GLIDE_DN = 2'd2
  } glide_state_t;

  localparam int TONE_BASE = 2048;

  function automatic logic [31:0] tone_tw(input logic [3:0] idx);
    return 32'(TONE_BASE) * (32'(idx) + 32'd1);
  endfunction

endpackage

// File: rtl/tone_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// accepted level and a one-cycle press pulse on each accepted rising edge.
// Ports:
//   clk   - system clock (rising edge)
//   rst   - synchronous active-high reset
//   btn   - raw asynchronous button level
//   press - one-cycle pulse when a high level has been accepted
module tone_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;
  logic          mismatch;
  logic          accept;

  assign mismatch = (sync2_reg != level_reg);
  // The level must differ for DEBOUNCE_CYCLES consecutive samples: the
  // counter holds the number of earlier differing samples, so acceptance
  // happens on the sample that finds it at DEBOUNCE_CYCLES-1.
  assign accept   = mismatch && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      if (!mismatch || accept) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (accept) begin
        level_reg <= sync2_reg;
      end
      // Pulse accompanies the newly accepted high level; falling edges
      // of the accepted level are ignored.
      press_reg <= accept && sync2_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/tone_ctrl.sv
// Tone selector with gliding DDS tuning word.
// Two debounced buttons step a tone index through a fixed table; the
// tuning word then slews toward the selected table entry by at most
// GLIDE_STEP per audio sample.
// Ports:
//   clk         - system clock (rising edge)
//   rst         - synchronous active-high reset
//   btn_up      - raw button, tone index up
//   btn_dn      - raw button, tone index down
//   sample_stb  - one-cycle pulse per audio sample
//   tuning_word - registered DDS tuning word
//   tone_idx    - registered current tone index
//   busy        - registered, high while the glide has not settled
module tone_ctrl
  import abies_tone_pkg::*;
#(
  parameter int TW              = 16,
  parameter int NUM_TONES       = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GLIDE_STEP      = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_up,
  input  logic          btn_dn,
  input  logic          sample_stb,
  output logic [TW-1:0] tuning_word,
  output logic [3:0]    tone_idx,
  output logic          busy
);

  localparam logic [3:0]    IDX_MAX  = 4'(NUM_TONES - 1);
  localparam logic [TW:0]   STEP     = (TW + 1)'(GLIDE_STEP);
  localparam logic [TW-1:0] TW_RESET = TW'(2048);

  // ---------------------------------------------------------------
  // Button conditioning: bit 0 = up, bit 1 = down
  // ---------------------------------------------------------------
  logic [1:0] btn_vec;
  logic [1:0] press_vec;

  assign btn_vec = {btn_dn, btn_up};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    tone_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_vec[gi]),
      .press(press_vec[gi])
    );
  end

  // ---------------------------------------------------------------
  // Tone table; all 16 index codes are populated so the 4-bit index
  // always addresses a defined entry.
  // ---------------------------------------------------------------
  logic [TW-1:0] tone_tab [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_tab
    assign tone_tab[gi] = TW'(tone_tw(4'(gi)));
  end

  // ---------------------------------------------------------------
  // Tone index
  // ---------------------------------------------------------------
  logic [3:0] idx_reg;
  logic [3:0] idx_next;

  always_comb begin
    idx_next = idx_reg;
    if (press_vec[0] && !press_vec[1] && (idx_reg != IDX_MAX)) begin
      idx_next = idx_reg + 4'd1;
    end else if (press_vec[1] && !press_vec[0] && (idx_reg != 4'd0)) begin
      idx_next = idx_reg - 4'd1;
    end
  end

  // ---------------------------------------------------------------
  // Glide FSM
  // ---------------------------------------------------------------
  logic [TW-1:0] target_reg;
  logic [TW-1:0] tw_reg;
  logic [TW-1:0] tw_next;
  logic [TW:0]   diff;
  logic          busy_reg;
  glide_state_t  state_reg;
  glide_state_t  state_next;

  always_comb begin
    state_next = HOLD;
    tw_next    = tw_reg;
    diff       = '0;
    // Classification always uses the live target and tuning word, so a
    // retarget reverses the direction on the very next strobe.
    if (target_reg > tw_reg) begin
      state_next = GLIDE_UP;
      diff       = {1'b0, target_reg} - {1'b0, tw_reg};
    end else if (target_reg < tw_reg) begin
      state_next = GLIDE_DN;
      diff       = {1'b0, tw_reg} - {1'b0, target_reg};
    end
    if (sample_stb && (state_reg != HOLD)) begin
      // Snapping when within one step avoids overshoot; a full step is
      // only taken when the gap exceeds it, so no wrap is possible.
      if (diff <= STEP) begin
        tw_next = target_reg;
      end else if (state_next == GLIDE_UP) begin
        tw_next = tw_reg + STEP[TW-1:0];
      end else begin
        tw_next = tw_reg - STEP[TW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg    <= 4'd0;
      target_reg <= TW_RESET;
      tw_reg     <= TW_RESET;
      state_reg  <= HOLD;
      busy_reg   <= 1'b0;
    end else begin
      idx_reg    <= idx_next;
      target_reg <= tone_tab[idx_reg];
      tw_reg     <= tw_next;
      state_reg  <= state_next;
      // Registered alongside the state so busy always mirrors it.
      busy_reg   <= (state_next != HOLD);
    end
  end

  assign tuning_word = tw_reg;
  assign tone_idx    = idx_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_tone_ctrl.sv
// Scoreboard bench for tone_ctrl: the stimulus side updates a behavioural
// model and queues expected tuning-word / tone-index values; a negedge
// monitor pops and compares whenever the DUT output changes.
module tb_tone_ctrl;

  localparam int TW   = 16;
  localparam int NT   = 8;
  localparam int DB   = 4;
  localparam int STEP = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_up;
  logic          btn_dn;
  logic          sample_stb;
  logic [TW-1:0] tuning_word;
  logic [3:0]    tone_idx;
  logic          busy;

  tone_ctrl #(
    .TW(TW), .NUM_TONES(NT), .DEBOUNCE_CYCLES(DB), .GLIDE_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .sample_stb(sample_stb), .tuning_word(tuning_word),
    .tone_idx(tone_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_tw[$];
  int exp_idx[$];
  int m_tw  = 2048;
  int m_idx = 0;
  int m_tgt = 2048;
  bit stb_en = 1'b0;
  int stb_count = 0;
  int stb_phase = 0;
  bit mon_en = 1'b0;
  int prev_tw = 0;
  int prev_idx = 0;
  int mon_e;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Strobe generator: one pulse every 4 cycles while enabled.
  initial begin
    sample_stb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stb_phase = (stb_phase + 1) % 4;
      if (stb_en && stb_phase == 0) begin
        sample_stb = 1'b1;
        stb_count++;
      end else begin
        sample_stb = 1'b0;
      end
    end
  end

  // Monitor: every output change is one transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(tuning_word) != prev_tw) begin
        prev_tw = int'(tuning_word);
        if (exp_tw.size() == 0) begin
          check("tw_unexpected_change", prev_tw, -1);
        end else begin
          mon_e = exp_tw.pop_front();
          $display("txn tuning_word=%0d expected=%0d", prev_tw, mon_e);
          check("tw_step", prev_tw, mon_e);
        end
      end
      if (int'(tone_idx) != prev_idx) begin
        prev_idx = int'(tone_idx);
        if (exp_idx.size() == 0) begin
          check("idx_unexpected_change", prev_idx, -1);
        end else begin
          mon_e = exp_idx.pop_front();
          $display("txn tone_idx=%0d expected=%0d", prev_idx, mon_e);
          check("tone_idx", prev_idx, mon_e);
        end
      end
    end
  end

  // Reference model: glide moves by at most STEP toward target, snapping
  // when within one step.
  function automatic int step_tw(int tw, int tg);
    if (tw == tg) return tw;
    if (tg > tw) return (tg - tw <= STEP) ? tg : tw + STEP;
    return (tw - tg <= STEP) ? tg : tw - STEP;
  endfunction

  task automatic model_press(bit up, bit dn);
    int ni;
    ni = m_idx;
    if (up && !dn && m_idx < NT - 1) ni = m_idx + 1;
    else if (dn && !up && m_idx > 0) ni = m_idx - 1;
    if (ni != m_idx) exp_idx.push_back(ni);
    m_idx = ni;
    m_tgt = 2048 * (m_idx + 1);
  endtask

  // Hold buttons for 'hold' sampled cycles; DB or more counts as a press.
  task automatic press(bit up, bit dn, int hold);
    if (hold >= DB) model_press(up, dn);
    @(negedge clk);
    btn_up = up;
    btn_dn = dn;
    repeat (hold) @(negedge clk);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic run_strobes(int n);
    int start;
    int guard;
    start = stb_count;
    guard = 0;
    stb_en = 1'b1;
    while (stb_count < start + n && guard < 8 * n + 16) begin
      @(negedge clk);
      guard++;
    end
    stb_en = 1'b0;
    if (stb_count < start + n) check("strobe_timeout", stb_count - start, n);
    repeat (6) @(negedge clk);
  endtask

  // k < 0: run until the model settles; otherwise exactly k strobes.
  task automatic glide(int k);
    int n;
    n = 0;
    while (m_tw != m_tgt && (k < 0 || n < k)) begin
      m_tw = step_tw(m_tw, m_tgt);
      exp_tw.push_back(m_tw);
      n++;
    end
    if (k < 0) begin
      if (n > 0) run_strobes(n);
    end else begin
      run_strobes(k);
    end
  endtask

  task automatic check_settled(string tag);
    check({tag, "_tw"}, int'(tuning_word), m_tw);
    check({tag, "_idx"}, int'(tone_idx), m_idx);
    check({tag, "_busy"}, int'(busy), (m_tw != m_tgt) ? 1 : 0);
  endtask

  task automatic do_reset(bit hold_up);
    if (m_tw != 2048) exp_tw.push_back(2048);
    if (m_idx != 0) exp_idx.push_back(0);
    m_tw = 2048; m_idx = 0; m_tgt = 2048;
    @(negedge clk);
    rst = 1'b1;
    btn_up = hold_up;
    @(negedge clk);
    check("rst_tw", int'(tuning_word), 2048);
    check("rst_idx", int'(tone_idx), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    btn_up = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int op;
    int u;
    rst = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;

    // Reset
    do_reset(1'b0);
    prev_tw  = int'(tuning_word);
    prev_idx = int'(tone_idx);
    mon_en   = 1'b1;

    // Long up press, then glide 2048 -> 4096 with busy-fall timing
    press(1'b1, 1'b0, 12);
    check("up_idx", int'(tone_idx), 1);
    check("up_busy_before_glide", int'(busy), 1);
    exp_tw.push_back(2560); exp_tw.push_back(3072);
    exp_tw.push_back(3584); exp_tw.push_back(4096);
    m_tw = 4096;
    stb_en = 1'b1;
    guard = 0;
    while (int'(tuning_word) != 4096 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    stb_en = 1'b0;
    check("glide_reached_4096", int'(tuning_word), 4096);
    check("busy_at_final_step", int'(busy), 1);
    @(negedge clk);
    check("busy_fall", int'(busy), 0);
    repeat (6) @(negedge clk);

    // Short pulse (3 samples) must not press; 4 samples must
    press(1'b1, 1'b0, 3);
    check_settled("short_pulse");
    press(1'b1, 1'b0, 4);
    check("boundary_press_idx", int'(tone_idx), 2);
    glide(-1);
    check_settled("idx2");

    // Down to 0 and saturate
    press(1'b0, 1'b1, 6);
    press(1'b0, 1'b1, 6);
    glide(-1);
    press(1'b0, 1'b1, 6);
    check_settled("dn_sat");

    // Nine up presses saturate at 7
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 6);
    glide(-1);
    check("up_sat_idx", int'(tone_idx), 7);
    check("up_sat_tw", int'(tuning_word), 16384);
    press(1'b1, 1'b1, 8);
    check_settled("both");

    // Back to idx 0, then retarget mid-glide
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 6);
    glide(-1);
    check_settled("back0");
    press(1'b1, 1'b0, 6);
    glide(1);
    check("retarget_first_step", int'(tuning_word), 2560);
    press(1'b0, 1'b1, 6);
    glide(1);
    check("retarget_snap", int'(tuning_word), 2048);
    check("retarget_busy", int'(busy), 0);

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1: press(1'b1, 1'b0, int'($urandom_range(4, 14)));
        2:    press(1'b0, 1'b1, int'($urandom_range(4, 14)));
        3: begin
          u = int'($urandom_range(0, 2));
          press(u != 1, u != 0, int'($urandom_range(1, 3)));
        end
        4:    press(1'b1, 1'b1, int'($urandom_range(4, 14)));
        default: glide(int'($urandom_range(1, 3)));
      endcase
      if ($urandom_range(0, 1) != 0) glide(-1);
      check_settled("rnd");
    end

    // Reset mid-glide with a button held across reset
    do_reset(1'b0);
    press(1'b1, 1'b0, 6);
    glide(2);
    check("pre_reset_tw", int'(tuning_word), 3072);
    do_reset(1'b1);
    repeat (20) @(negedge clk);
    check_settled("post_reset");

    check("exp_tw_drained", exp_tw.size(), 0);
    check("exp_idx_drained", exp_idx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
